// File: rtl/riscv_alu_seq.sv
// riscv_alu_seq: EX-stage ALU, combinational ops plus iterative restoring divider.
// Optional: define RISCV_ALU_DIV_EARLY_TERM_EN to skip leading zeros of |dividend|.

package riscv_defines;
    localparam int ALU_OP_WIDTH = 7;

    localparam logic [ALU_OP_WIDTH-1:0] ALU_ADD   = 7'b0011000;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_SUB   = 7'b0011001;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_XOR   = 7'b0101111;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_OR    = 7'b0101110;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_AND   = 7'b0010101;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_SRA   = 7'b0100100;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_SRL   = 7'b0100101;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_SLL   = 7'b0100111;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_LTS   = 7'b0000000;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_LTU   = 7'b0000001;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_SLTS  = 7'b0000010;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_SLTU  = 7'b0000011;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_LES   = 7'b0000100;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_LEU   = 7'b0000101;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_SLETS = 7'b0000110;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_SLETU = 7'b0000111;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_GTS   = 7'b0001000;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_GTU   = 7'b0001001;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_GES   = 7'b0001010;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_GEU   = 7'b0001011;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_EQ    = 7'b0001100;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_NE    = 7'b0001101;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_DIVU  = 7'b0110000;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_DIV   = 7'b0110001;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_REMU  = 7'b0110010;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_REM   = 7'b0110011;
endpackage

module riscv_alu_seq
    import riscv_defines::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    enable_i,
    input  logic [ALU_OP_WIDTH-1:0] operator_i,
    input  logic [WIDTH-1:0]        operand_a_i,
    input  logic [WIDTH-1:0]        operand_b_i,
    output logic [WIDTH-1:0]        result_o,
    output logic                    comparison_result_o,
    output logic                    ready_o,
    input  logic                    ex_ready_i
);

    localparam int SH_W = $clog2(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DIV,
        S_FINISH
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] quot_q, quot_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic             negq_q, negq_d;
    logic             negr_q, negr_d;
    logic             isrem_q, isrem_d;

    logic             is_div_op;
    logic             signed_op;
    logic             is_rem_op;
    logic             a_neg;
    logic             b_neg;
    logic [WIDTH-1:0] a_abs;
    logic [WIDTH-1:0] b_abs;
    logic             b_zero;
    logic [SH_W-1:0]  shamt;
    logic [WIDTH-1:0] alu_res;
    logic             cmp;
    logic             op_valid;
    logic             lts;
    logic             ltu;
    logic             eq;
    logic [WIDTH:0]   rem_shift;
    logic [WIDTH:0]   diff;
    logic [WIDTH-1:0] fin_res;

    assign is_div_op = (operator_i == ALU_DIV)  || (operator_i == ALU_DIVU) ||
                       (operator_i == ALU_REM)  || (operator_i == ALU_REMU);
    assign signed_op = (operator_i == ALU_DIV)  || (operator_i == ALU_REM);
    assign is_rem_op = (operator_i == ALU_REM)  || (operator_i == ALU_REMU);

    assign a_neg  = signed_op & operand_a_i[WIDTH-1];
    assign b_neg  = signed_op & operand_b_i[WIDTH-1];
    assign a_abs  = a_neg ? -operand_a_i : operand_a_i;
    assign b_abs  = b_neg ? -operand_b_i : operand_b_i;
    assign b_zero = (operand_b_i == '0);
    assign shamt  = operand_b_i[SH_W-1:0];

    assign lts = $signed(operand_a_i) < $signed(operand_b_i);
    assign ltu = operand_a_i < operand_b_i;
    assign eq  = operand_a_i == operand_b_i;

    // One restoring step: shift in next dividend bit, trial-subtract divisor.
    assign rem_shift = {rem_q, quot_q[WIDTH-1]};
    assign diff      = rem_shift - {1'b0, dvs_q};

    assign fin_res = isrem_q ? (negr_q ? -rem_q : rem_q)
                             : (negq_q ? -quot_q : quot_q);

`ifdef RISCV_ALU_DIV_EARLY_TERM_EN
    logic [CNT_W-1:0] clz;

    // Leading-zero count of |a|; the highest set bit wins.
    always_comb begin
        clz = CNT_W'(WIDTH);
        for (int i = 0; i < WIDTH; i++) begin
            if (a_abs[i]) clz = CNT_W'(WIDTH - 1 - i);
        end
    end
`endif

    // Single-cycle operations, purely combinational from the operands.
    always_comb begin
        alu_res  = '0;
        cmp      = 1'b0;
        op_valid = 1'b1;
        unique case (operator_i)
            ALU_ADD:   alu_res = operand_a_i + operand_b_i;
            ALU_SUB:   alu_res = operand_a_i - operand_b_i;
            ALU_AND:   alu_res = operand_a_i & operand_b_i;
            ALU_OR:    alu_res = operand_a_i | operand_b_i;
            ALU_XOR:   alu_res = operand_a_i ^ operand_b_i;
            ALU_SLL:   alu_res = operand_a_i << shamt;
            ALU_SRL:   alu_res = operand_a_i >> shamt;
            ALU_SRA:   alu_res = $unsigned($signed(operand_a_i) >>> shamt);
            ALU_LTS:   begin cmp = lts;        alu_res = {WIDTH{cmp}}; end
            ALU_LTU:   begin cmp = ltu;        alu_res = {WIDTH{cmp}}; end
            ALU_LES:   begin cmp = lts | eq;   alu_res = {WIDTH{cmp}}; end
            ALU_LEU:   begin cmp = ltu | eq;   alu_res = {WIDTH{cmp}}; end
            ALU_GTS:   begin cmp = ~(lts | eq); alu_res = {WIDTH{cmp}}; end
            ALU_GTU:   begin cmp = ~(ltu | eq); alu_res = {WIDTH{cmp}}; end
            ALU_GES:   begin cmp = ~lts;       alu_res = {WIDTH{cmp}}; end
            ALU_GEU:   begin cmp = ~ltu;       alu_res = {WIDTH{cmp}}; end
            ALU_EQ:    begin cmp = eq;         alu_res = {WIDTH{cmp}}; end
            ALU_NE:    begin cmp = ~eq;        alu_res = {WIDTH{cmp}}; end
            ALU_SLTS:  begin cmp = lts;        alu_res = {{(WIDTH-1){1'b0}}, cmp}; end
            ALU_SLTU:  begin cmp = ltu;        alu_res = {{(WIDTH-1){1'b0}}, cmp}; end
            ALU_SLETS: begin cmp = lts | eq;   alu_res = {{(WIDTH-1){1'b0}}, cmp}; end
            ALU_SLETU: begin cmp = ltu | eq;   alu_res = {{(WIDTH-1){1'b0}}, cmp}; end
            ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU: alu_res = '0;
            default:   op_valid = 1'b0;
        endcase
    end

    // Divider next state and ALU outputs.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        quot_d  = quot_q;
        rem_d   = rem_q;
        dvs_d   = dvs_q;
        negq_d  = negq_q;
        negr_d  = negr_q;
        isrem_d = isrem_q;
        ready_o             = 1'b1;
        result_o            = alu_res;
        comparison_result_o = cmp;

        unique case (state_q)
            S_IDLE: begin
                if (enable_i && is_div_op) begin
                    ready_o = 1'b0;
                    dvs_d   = b_abs;
                    isrem_d = is_rem_op;
                    negq_d  = a_neg ^ b_neg;
                    negr_d  = a_neg;
                    rem_d   = '0;
                    quot_d  = a_abs;
                    cnt_d   = CNT_W'(WIDTH - 1);
                    state_d = S_DIV;
`ifdef RISCV_ALU_DIV_EARLY_TERM_EN
                    quot_d = a_abs << clz;
                    cnt_d  = CNT_W'(WIDTH - 1) - clz;
                    if (a_abs == '0) begin
                        quot_d  = '0;
                        negq_d  = 1'b0;
                        negr_d  = 1'b0;
                        state_d = S_FINISH;
                    end
`endif
                    // Divide by zero: all-ones quotient, dividend as remainder.
                    if (b_zero) begin
                        quot_d  = '1;
                        rem_d   = a_abs;
                        negq_d  = 1'b0;
                        negr_d  = a_neg;
                        state_d = S_FINISH;
                    end
                end
            end
            S_DIV: begin
                ready_o             = 1'b0;
                result_o            = '0;
                comparison_result_o = 1'b0;
                quot_d = {quot_q[WIDTH-2:0], ~diff[WIDTH]};
                rem_d  = diff[WIDTH] ? rem_shift[WIDTH-1:0] : diff[WIDTH-1:0];
                cnt_d  = cnt_q - 1'b1;
                if (cnt_q == '0) state_d = S_FINISH;
            end
            S_FINISH: begin
                result_o            = fin_res;
                comparison_result_o = 1'b0;
                if (ex_ready_i) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        if (rst) begin
            ready_o             = 1'b1;
            result_o            = '0;
            comparison_result_o = 1'b0;
        end
    end

    // Divider state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            quot_q  <= '0;
            rem_q   <= '0;
            dvs_q   <= '0;
            negq_q  <= 1'b0;
            negr_q  <= 1'b0;
            isrem_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
            dvs_q   <= dvs_d;
            negq_q  <= negq_d;
            negr_q  <= negr_d;
            isrem_q <= isrem_d;
        end
    end

`ifndef SYNTHESIS
    // Flag unsupported operators issued while idle.
    always @(posedge clk) begin
        if (!rst && enable_i && state_q == S_IDLE && !op_valid)
            $warning("riscv_alu_seq: unsupported operator %b", operator_i);
    end
`endif

endmodule

// File: tb/tb_riscv_alu_seq.sv
// tb_riscv_alu_seq: directed + random checks of riscv_alu_seq (WIDTH = 32)
// against a behavioural reference model.

module tb_riscv_alu_seq;
    import riscv_defines::*;

    localparam int W = 32;

    logic                    clk = 1'b0;
    logic                    rst = 1'b1;
    logic                    enable_i = 1'b0;
    logic [ALU_OP_WIDTH-1:0] operator_i = ALU_ADD;
    logic [W-1:0]            operand_a_i = 32'd5;
    logic [W-1:0]            operand_b_i = 32'd7;
    logic [W-1:0]            result_o;
    logic                    comparison_result_o;
    logic                    ready_o;
    logic                    ex_ready_i = 1'b0;

    int n_cmp = 0;
    int n_err = 0;

    riscv_alu_seq #(.WIDTH(W)) dut (
        .clk                 (clk),
        .rst                 (rst),
        .enable_i            (enable_i),
        .operator_i          (operator_i),
        .operand_a_i         (operand_a_i),
        .operand_b_i         (operand_b_i),
        .result_o            (result_o),
        .comparison_result_o (comparison_result_o),
        .ready_o             (ready_o),
        .ex_ready_i          (ex_ready_i)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic bit is_cmp_op(input logic [ALU_OP_WIDTH-1:0] op);
        return op inside {ALU_LTS, ALU_LTU, ALU_LES, ALU_LEU, ALU_GTS, ALU_GTU,
                          ALU_GES, ALU_GEU, ALU_EQ, ALU_NE,
                          ALU_SLTS, ALU_SLTU, ALU_SLETS, ALU_SLETU};
    endfunction

    function automatic bit ref_cmp(input logic [ALU_OP_WIDTH-1:0] op,
                                   input logic [W-1:0] a, input logic [W-1:0] b);
        longint sa = longint'($signed(a));
        longint sb = longint'($signed(b));
        longint ua = longint'(a);
        longint ub = longint'(b);
        case (op)
            ALU_LTS, ALU_SLTS:   return sa < sb;
            ALU_LTU, ALU_SLTU:   return ua < ub;
            ALU_LES, ALU_SLETS:  return sa <= sb;
            ALU_LEU, ALU_SLETU:  return ua <= ub;
            ALU_GTS:             return sa > sb;
            ALU_GTU:             return ua > ub;
            ALU_GES:             return sa >= sb;
            ALU_GEU:             return ua >= ub;
            ALU_EQ:              return ua == ub;
            ALU_NE:              return ua != ub;
            default:             return 1'b0;
        endcase
    endfunction

    function automatic logic [W-1:0] ref_res(input logic [ALU_OP_WIDTH-1:0] op,
                                             input logic [W-1:0] a, input logic [W-1:0] b);
        logic signed [W-1:0] sa = a;
        logic signed [W-1:0] sb = b;
        int sh = int'(b % W);
        bit ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        logic [W-1:0] r;
        case (op)
            ALU_ADD: r = a + b;
            ALU_SUB: r = a - b;
            ALU_AND: r = a & b;
            ALU_OR:  r = a | b;
            ALU_XOR: r = a ^ b;
            ALU_SLL: r = a << sh;
            ALU_SRL: r = a >> sh;
            ALU_SRA: r = sa >>> sh;
            ALU_SLTS, ALU_SLTU, ALU_SLETS, ALU_SLETU:
                r = W'(ref_cmp(op, a, b));
            ALU_DIVU: begin
                if (b == 0) r = '1;
                else        r = a / b;
            end
            ALU_REMU: begin
                if (b == 0) r = a;
                else        r = a % b;
            end
            ALU_DIV: begin
                if (b == 0)   r = '1;
                else if (ovf) r = a;
                else          r = sa / sb;
            end
            ALU_REM: begin
                if (b == 0)   r = a;
                else if (ovf) r = '0;
                else          r = sa % sb;
            end
            default: r = ref_cmp(op, a, b) ? '1 : '0;
        endcase
        return r;
    endfunction

    // Cycle (counting the issue cycle as 0) at which ready_o returns high.
    function automatic int ref_lat(input logic [ALU_OP_WIDTH-1:0] op,
                                   input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] m;
        int n;
        if (b == 0) return 1;
        m = a;
        if ((op == ALU_DIV || op == ALU_REM) && a[W-1]) m = -a;
        n = 0;
`ifdef RISCV_ALU_DIV_EARLY_TERM_EN
        if (m == 0) return 1;
        while (m != 0) begin
            n++;
            m = m >> 1;
        end
        return n + 1;
`else
        return W + 1 + n - n + ((m == 0) ? 0 : 0);
`endif
    endfunction

    task automatic idle_check(input string tag);
        logic [W-1:0] a;
        logic [W-1:0] b;
        a = $urandom;
        b = $urandom;
        @(negedge clk);
        enable_i    = 1'b0;
        ex_ready_i  = 1'b0;
        operator_i  = ALU_ADD;
        operand_a_i = a;
        operand_b_i = b;
        #1;
        chk({tag, "_idle_res"}, result_o, a + b);
        chk({tag, "_idle_rdy"}, W'(ready_o), W'(1));
    endtask

    task automatic run_div(input string tag, input logic [ALU_OP_WIDTH-1:0] op,
                           input logic [W-1:0] a, input logic [W-1:0] b,
                           input int hold, input bit reissue);
        logic [W-1:0] exp;
        int lat;
        exp = ref_res(op, a, b);
        @(negedge clk);
        enable_i    = 1'b1;
        ex_ready_i  = 1'b0;
        operator_i  = op;
        operand_a_i = a;
        operand_b_i = b;
        #1;
        chk({tag, "_issue_rdy"}, W'(ready_o), W'(0));
        lat = 0;
        for (int k = 1; k <= 200; k++) begin
            @(negedge clk);
            enable_i    = 1'b0;
            operand_a_i = $urandom;
            operand_b_i = $urandom;
            #1;
            if (ready_o === 1'b1) begin
                lat = k;
                break;
            end
        end
        chk({tag, "_lat"}, W'(lat), W'(ref_lat(op, a, b)));
        chk({tag, "_res"}, result_o, exp);
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            operand_a_i = $urandom;
            #1;
            chk({tag, "_hold_res"}, result_o, exp);
            chk({tag, "_hold_rdy"}, W'(ready_o), W'(1));
        end
        @(negedge clk);
        ex_ready_i = 1'b1;
        if (reissue) begin
            enable_i   = 1'b1;
            operator_i = ALU_DIVU;
        end
        #1;
        chk({tag, "_rel_rdy"}, W'(ready_o), W'(1));
        idle_check(tag);
    endtask

    logic [ALU_OP_WIDTH-1:0] ops [22] = '{
        ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_SLL, ALU_SRL, ALU_SRA,
        ALU_LTS, ALU_LTU, ALU_LES, ALU_LEU, ALU_GTS, ALU_GTU, ALU_GES, ALU_GEU,
        ALU_EQ, ALU_NE, ALU_SLTS, ALU_SLTU, ALU_SLETS, ALU_SLETU
    };
    logic [ALU_OP_WIDTH-1:0] dops [4] = '{ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU};

    initial begin
        logic [ALU_OP_WIDTH-1:0] op;
        logic [W-1:0] a;
        logic [W-1:0] b;

        // Reset state
        #1;
        chk("rst_rdy", W'(ready_o), W'(1));
        chk("rst_res", result_o, '0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Directed single-cycle
        @(negedge clk);
        operator_i  = ALU_SUB;
        operand_a_i = 32'd5;
        operand_b_i = 32'd7;
        #1;
        chk("sub_res", result_o, 32'hFFFF_FFFE);
        chk("sub_rdy", W'(ready_o), W'(1));
        @(negedge clk);
        operator_i  = ALU_SLTS;
        operand_a_i = 32'hFFFF_FFFF;
        operand_b_i = 32'd1;
        #1;
        chk("slts_res", result_o, 32'h0000_0001);
        chk("slts_cmp", W'(comparison_result_o), W'(1));

        // Random single-cycle ops
        for (int i = 0; i < 200; i++) begin
            op = ops[$urandom_range(0, 21)];
            a = $urandom;
            b = (i % 4 == 0) ? a : $urandom;
            if (i % 7 == 0) a = 32'h8000_0000;
            @(negedge clk);
            operator_i  = op;
            operand_a_i = a;
            operand_b_i = b;
            enable_i    = 1'(i % 2);
            #1;
            chk("rnd_res", result_o, ref_res(op, a, b));
            chk("rnd_rdy", W'(ready_o), W'(1));
            if (is_cmp_op(op))
                chk("rnd_cmp", W'(comparison_result_o), W'(ref_cmp(op, a, b)));
        end

        // Directed division
        run_div("divu", ALU_DIVU, 32'd100, 32'd7, 0, 1'b0);
        run_div("remu", ALU_REMU, 32'd100, 32'd7, 0, 1'b0);
        run_div("div_ovf", ALU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 0, 1'b0);
        run_div("rem_ovf", ALU_REM, 32'h8000_0000, 32'hFFFF_FFFF, 0, 1'b0);
        run_div("rem_neg", ALU_REM, -32'sd7, 32'd2, 0, 1'b0);
        run_div("divu_z", ALU_DIVU, 32'h1234, 32'd0, 0, 1'b0);
        run_div("remu_z", ALU_REMU, 32'h1234, 32'd0, 0, 1'b0);
        run_div("div_z", ALU_DIV, -32'sd9, 32'd0, 0, 1'b0);
        run_div("rem_z", ALU_REM, -32'sd9, 32'd0, 0, 1'b0);
        run_div("div_a0", ALU_DIV, 32'd0, 32'd5, 0, 1'b0);
        run_div("hold", ALU_DIV, -32'sd1000, 32'd7, 3, 1'b0);
        run_div("reiss", ALU_REMU, 32'hDEAD_BEEF, 32'd13, 0, 1'b1);

        // Reset in the middle of a division
        @(negedge clk);
        enable_i    = 1'b1;
        operator_i  = ALU_DIVU;
        operand_a_i = 32'hFFFF_0000;
        operand_b_i = 32'd3;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            enable_i = 1'b0;
        end
        rst = 1'b1;
        #1;
        chk("midrst_rdy", W'(ready_o), W'(1));
        chk("midrst_res", result_o, '0);
        @(negedge clk);
        rst = 1'b0;
        idle_check("midrst");
        run_div("post_rst", ALU_DIVU, 32'd9, 32'd3, 0, 1'b0);

        // Random division
        for (int i = 0; i < 24; i++) begin
            op = dops[$urandom_range(0, 3)];
            a = $urandom;
            if (i % 3 == 0) a = a >> $urandom_range(0, 31);
            if (i % 5 == 1) a = -a;
            case (i % 8)
                0:       b = '0;
                1:       b = '1;
                2:       b = 32'($urandom_range(1, 20));
                3:       b = -32'($urandom_range(1, 20));
                default: b = $urandom >> $urandom_range(0, 31);
            endcase
            run_div("rnd_div", op, a, b, i % 2, 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
